regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Register file and write-back pipeline for the MIPS core. Takes the execute stage's result triple (destination address, write enable, write data), carries it through a MEM and a WB pipeline register, and commits it to a 32×32-bit register array. Also serves the decode stage's two operand read ports, with forwarding from every in-flight result so decode always sees the newest value.

## Interface
Parameters: none. Widths are fixed: 32 registers of 32 bits, 5-bit addresses.

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  freeze MEM/WB registers and suppress commit
- ex_dest_addr  in  5  destination register from execute
- ex_write  in  1  execute result is to be written
- ex_wdata  in  32  execute result value
- re1 / re2  in  1  read enable, ports 1/2
- raddr1 / raddr2  in  5  read address, ports 1/2
- rdata1 / rdata2  out  32  read data, ports 1/2 (combinational)
- wb_dest_addr  out  5  WB-stage address (registered)
- wb_write  out  1  WB stage commits this cycle (registered)
- wb_wdata  out  32  WB-stage data (registered)

## Operation
- Valid-write qualification: a write is valid only when write=1 and dest≠0. When ex_write=1 and ex_dest_addr=0, the MEM stage latches write=0.
- Pipeline advance: on each edge with rst=0 and stall=0:
  - MEM ← {ex_dest_addr, qualified ex_write, ex_wdata}
  - WB ← MEM
  - if WB.write=1, array[WB.addr] ← WB.data using the pre-edge WB contents
- Stall: with stall=1 and rst=0, MEM, WB and the array all hold. No commit happens, and the held WB entry commits exactly once, on the first non-stalled edge.
- Read port (each port independent):
  - rst=1 or re=0 → 0
  - raddr=0 → 0
  - otherwise, highest-priority match:
    1. EX inputs (ex_write=1 and ex_dest_addr==raddr)
    2. MEM stage
    3. WB stage
    4. array
  - Forwarding also applies while stall=1.
- Register 0 is hardwired to zero and is never written.
- Both ports may read the same address. Each resolves independently to an identical value.

## Timing
- Reset values: MEM and WB registers all zero (write=0, addr=0, data=0); every array entry 0. Outputs wb_dest_addr=0, wb_write=0, wb_wdata=0, and rdata1/rdata2=0 while rst=1.
- rst takes priority over stall. Reset mid-operation discards all in-flight results with no commit.
- Result path for a value presented on the EX inputs in cycle N (no stall):
  - cycle N: forwarded combinationally
  - cycle N+1: in MEM
  - cycle N+2: in WB (wb_write=1)
  - committed at the edge ending N+2
  - visible from the array in cycle N+3
- Read-after-write has zero bubbles at any distance.
- Each stall cycle extends the residency of MEM and WB by one cycle.
- Back-to-back writes to the same register: the younger write wins on reads from the cycle it appears. The array ends holding the youngest value.
- Simultaneous events:
  - Commit and read of the same address in the same cycle return the WB value via forwarding, never the stale array value.
  - EX, MEM and WB all matching the same address return the EX value.

## Test plan
- Reset: drive rst=1 for 2 cycles mid-stream with MEM/WB holding writes to r5. Then, with rst=0, re1=1, raddr1=5 → rdata1=0 and wb_write=0; the array holds r5=0.
- Commit latency: cycle 0 drive ex_write=1, ex_dest_addr=3, ex_wdata=0x12345678, then ex_write=0. raddr1=3 → 0x12345678 in cycles 0, 1, 2 and 3+. wb_write=1 with wb_dest_addr=3 in cycle 2 only.
- Priority: write r7=0x1 in cycle 0, 0x2 in cycle 1, 0x3 in cycle 2. Required reads of raddr2=7: cycle 2 → 0x3, cycle 3 → 0x3, cycle 5 → 0x3, and the array finally holds 0x3.
- r0 and read enable:
  - ex_write=1, ex_dest_addr=0, ex_wdata=0xFFFFFFFF → raddr1=0 reads 0 in every cycle, and wb_write stays 0 when that entry reaches WB.
  - re2=0 with raddr2=3 after r3 is written → rdata2=0.
- Stall: write r9=0xAB, assert stall for 3 cycles starting when the entry is in WB.
  - wb_write stays 1 throughout, and raddr1=9 reads 0xAB every cycle.
  - Exactly one commit occurs, after stall drops; the array then holds r9=0xAB.
- Dual port: raddr1=raddr2=4 while r4 is being forwarded from MEM with value 0x55 → rdata1=rdata2=0x55.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   32x32 register file with a two-stage (MEM, WB) write-back pipeline and
//   full result forwarding on two combinational read ports.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold MEM/WB and suppress the commit
//   ex_dest_addr/ex_write/ex_wdata   result triple from execute
//   re1/raddr1/rdata1   read port 1 (combinational)
//   re2/raddr2/rdata2   read port 2 (combinational)
//   wb_dest_addr/wb_write/wb_wdata   registered WB-stage contents

module regfile_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  ex_dest_addr,
    input  logic        ex_write,
    input  logic [31:0] ex_wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [4:0]  wb_dest_addr,
    output logic        wb_write,
    output logic [31:0] wb_wdata
);

    logic [4:0]  mem_addr_q, mem_addr_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_write_q, wb_write_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // Writes to r0 are dropped at entry so they never look like real
    // writes to forwarding or commit downstream.
    logic ex_valid;
    assign ex_valid = ex_write && (ex_dest_addr != 5'd0);

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_data_d  = mem_data_q;
        wb_addr_d   = wb_addr_q;
        wb_write_d  = wb_write_q;
        wb_data_d   = wb_data_q;
        rf_d        = rf_q;
        if (!stall) begin
            mem_addr_d  = ex_dest_addr;
            mem_write_d = ex_valid;
            mem_data_d  = ex_wdata;
            wb_addr_d   = mem_addr_q;
            wb_write_d  = mem_write_q;
            wb_data_d   = mem_data_q;
            // Commit uses the pre-edge WB contents; a stalled WB entry
            // therefore commits exactly once, on the first free edge.
            if (wb_write_q && (wb_addr_q != 5'd0))
                rf_d[wb_addr_q] = wb_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_data_q  <= '0;
            wb_addr_q   <= '0;
            wb_write_q  <= 1'b0;
            wb_data_q   <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_data_q  <= mem_data_d;
            wb_addr_q   <= wb_addr_d;
            wb_write_q  <= wb_write_d;
            wb_data_q   <= wb_data_d;
            rf_q        <= rf_d;
        end
    end

    // Youngest in-flight producer wins: EX, then MEM, then WB, then array.
    // A WB entry being committed this edge is still served from WB, so a
    // same-cycle read never sees the stale array value.
    function automatic logic [31:0] fwd_read(
        input logic        en,
        input logic [4:0]  a,
        input logic [31:0] arr_val,
        input logic        r,
        input logic        exv,
        input logic [4:0]  exa,
        input logic [31:0] exd,
        input logic        mw,
        input logic [4:0]  ma,
        input logic [31:0] md,
        input logic        ww,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        logic [31:0] v;
        if (r || !en || (a == 5'd0))
            v = '0;
        else if (exv && (exa == a))
            v = exd;
        else if (mw && (ma == a))
            v = md;
        else if (ww && (wa == a))
            v = wd;
        else
            v = arr_val;
        return v;
    endfunction

    assign rdata1 = fwd_read(re1, raddr1, rf_q[raddr1], rst,
                             ex_valid, ex_dest_addr, ex_wdata,
                             mem_write_q, mem_addr_q, mem_data_q,
                             wb_write_q, wb_addr_q, wb_data_q);
    assign rdata2 = fwd_read(re2, raddr2, rf_q[raddr2], rst,
                             ex_valid, ex_dest_addr, ex_wdata,
                             mem_write_q, mem_addr_q, mem_data_q,
                             wb_write_q, wb_addr_q, wb_data_q);

    assign wb_dest_addr = wb_addr_q;
    assign wb_write     = wb_write_q;
    assign wb_wdata     = wb_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed scenarios plus random traffic,
// checked against an architectural model (newest value per register, and
// the list of entries accepted into the pipeline) through a scoreboard queue.

module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [4:0]  ex_dest_addr;
    logic        ex_write;
    logic [31:0] ex_wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  wb_dest_addr;
    logic        wb_write;
    logic [31:0] wb_wdata;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_dest_addr(ex_dest_addr), .ex_write(ex_write), .ex_wdata(ex_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .wb_dest_addr(wb_dest_addr), .wb_write(wb_write), .wb_wdata(wb_wdata)
    );

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wa;
        logic        ww;
        logic [31:0] wd;
    } exp_t;

    typedef struct packed {
        logic [4:0]  a;
        logic        w;
        logic [31:0] d;
    } ent_t;

    exp_t        sb[$];
    ent_t        hist[$];      // entries accepted by the pipeline, oldest first
    logic [31:0] latest[32];   // newest value issued to each register
    int          n_checks = 0;
    int          n_pass = 0;

    // inputs of the cycle now ending (applied to the coming edge)
    logic        p_rst, p_stall, p_w;
    logic [4:0]  p_a;
    logic [31:0] p_d;

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'd0;
        if (ex_write && ex_dest_addr == a) return ex_wdata;
        return latest[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) latest[i] = 32'd0;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
    endtask

    task automatic cyc(input logic r, input logic s, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
        exp_t x;
        ent_t h;
        @(posedge clk);
        #1;
        // account for the edge that just happened
        if (p_rst) model_reset();
        else if (!p_stall) begin
            if (p_w && p_a != 0) latest[p_a] = p_d;
            h.a = p_a; h.w = p_w && (p_a != 0); h.d = p_d;
            hist.push_back(h);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        rst = r; stall = s; ex_write = w; ex_dest_addr = a; ex_wdata = d;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        p_rst = r; p_stall = s; p_w = w; p_a = a; p_d = d;
        h = hist[hist.size()-2];
        x.r1 = exp_read(e1, a1);
        x.r2 = exp_read(e2, a2);
        x.wa = h.a; x.ww = h.w; x.wd = h.d;
        sb.push_back(x);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(0, 0, 0, 5'd0, 32'd0, 1, a1, 1, a2);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // monitor: every cycle the DUT presents a full output set
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata1", rdata1, e.r1);
            chk("rdata2", rdata2, e.r2);
            chk("wb_dest_addr", {27'd0, wb_dest_addr}, {27'd0, e.wa});
            chk("wb_write", {31'd0, wb_write}, {31'd0, e.ww});
            chk("wb_wdata", wb_wdata, e.wd);
        end
    end

    initial begin
        int wait_cnt;
        rst = 1; stall = 0; ex_write = 0; ex_dest_addr = 0; ex_wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        p_rst = 1; p_stall = 0; p_w = 0; p_a = 0; p_d = 0;
        model_reset();
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 5);

        // reset discards in-flight writes to r5
        cyc(0, 0, 1, 5, 32'hDEAD0001, 1, 5, 1, 5);
        cyc(0, 0, 1, 5, 32'hDEAD0002, 1, 5, 1, 5);
        cyc(1, 1, 0, 0, 0, 1, 5, 1, 5);
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 5);
        repeat (4) idle(5, 5);

        // commit latency
        cyc(0, 0, 1, 3, 32'h12345678, 1, 3, 1, 3);
        repeat (4) idle(3, 3);

        // back-to-back writes to r7
        cyc(0, 0, 1, 7, 32'h1, 1, 7, 1, 7);
        cyc(0, 0, 1, 7, 32'h2, 1, 7, 1, 7);
        cyc(0, 0, 1, 7, 32'h3, 1, 7, 1, 7);
        repeat (4) idle(7, 7);

        // r0 never written; re2=0 gives 0
        cyc(0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
        repeat (3) idle(0, 0);
        cyc(0, 0, 0, 0, 0, 1, 3, 0, 3);

        // stall while r9 sits in WB
        cyc(0, 0, 1, 9, 32'hAB, 1, 9, 1, 9);
        idle(9, 9);
        repeat (3) cyc(0, 1, 0, 0, 0, 1, 9, 1, 9);
        repeat (4) idle(9, 9);

        // both ports on r4 forwarded from MEM
        cyc(0, 0, 1, 4, 32'h55, 1, 4, 1, 4);
        idle(4, 4);
        idle(4, 4);

        // random traffic over a small address window to stress forwarding
        for (int i = 0; i < 600; i++) begin
            logic r, s, w, e1, e2;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            w  = ($urandom_range(0, 99) < 60);
            e1 = ($urandom_range(0, 9) != 0);
            e2 = ($urandom_range(0, 9) != 0);
            cyc(r, s, w, 5'($urandom_range(0, 7)), $urandom,
                e1, 5'($urandom_range(0, 7)), e2, 5'($urandom_range(0, 7)));
        end
        for (int a = 0; a < 8; a++) idle(5'(a), 5'(7 - a));
        repeat (3) idle(1, 2);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
